// File: rtl/drive_pkg.sv
// Shared definitions for the motor-drive observer: motion codes, speed FSM
// states and the H-bridge direction decoder.
package drive_pkg;

   localparam logic [2:0] MOT_STOP    = 3'd0;
   localparam logic [2:0] MOT_FWD     = 3'd1;
   localparam logic [2:0] MOT_REV     = 3'd2;
   localparam logic [2:0] MOT_SPIN_R  = 3'd3;
   localparam logic [2:0] MOT_SPIN_L  = 3'd4;
   localparam logic [2:0] MOT_ILLEGAL = 3'd7;

   localparam logic [3:0] SPEED_MAX   = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HIGH = 2'b01,
      ST_LOW  = 2'b10
   } speed_state_e;

   // Pin order is {IN1, IN2, IN3, IN4}.
   function automatic logic [2:0] decode_motion(input logic [3:0] pins);
      logic [2:0] code;
      case (pins)
         4'b0000: code = MOT_STOP;
         4'b1010: code = MOT_FWD;
         4'b0101: code = MOT_REV;
         4'b0110: code = MOT_SPIN_R;
         4'b1001: code = MOT_SPIN_L;
         default: code = MOT_ILLEGAL;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for asynchronous pin inputs. Deliberately unreset so a
// reset never fabricates an edge on a pin that is already high.
module pin_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Metastability filter: two back-to-back capture stages.
   always_ff @(posedge clk) begin
      meta_r <= d;
      sync_r <= meta_r;
   end

   assign q = sync_r;

endmodule

// File: rtl/drive_monitor.sv
// Passive observer of the motor-driver pins: debounced motion code from the
// H-bridge lines and the 0-10 speed level recovered from the enable PWM.
module drive_monitor
   import drive_pkg::*;
#(
   parameter int PERIOD  = 100000,
   parameter int TOL     = 16,
   parameter int TIMEOUT = 200002,
   parameter int STABLE  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   input  logic       IN1,
   input  logic       IN2,
   input  logic       IN3,
   input  logic       IN4,
   output logic [2:0] motion,
   output logic       motion_chg,
   output logic [3:0] speed,
   output logic       speed_vld,
   output logic       period_err,
   output logic       pwm_stuck
);

   localparam int STEP = PERIOD / 10;
   localparam int PW   = $clog2(TIMEOUT + 1);
   localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;
   localparam int CW   = $clog2(STABLE + 1);

   localparam logic [PW-1:0] PER_MAX   = PW'(TIMEOUT);
   localparam logic [PW-1:0] PER_NOM   = PW'(PERIOD + 1);
   localparam logic [PW-1:0] PER_TOL   = PW'(TOL);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);
   localparam logic [CW-1:0] STAB_MAX  = CW'(STABLE);

   logic [4:0]    sync_s;
   logic          pwm_sync_s;
   logic [2:0]    code_s;
   logic          pwm_lvl_r;
   logic          rise_r;
   logic          fall_r;

   logic [2:0]    cand_r;
   logic [CW-1:0] stab_cnt_r;
   logic [CW-1:0] stab_next_s;

   speed_state_e  state_r;
   speed_state_e  state_next_s;
   logic [PW-1:0] per_cnt_r;
   logic [PW-1:0] per_inc_s;
   logic [PW-1:0] per_next_s;
   logic [PW-1:0] per_dev_s;
   logic [SW-1:0] step_cnt_r;
   logic [SW-1:0] step_base_s;
   logic [SW-1:0] step_next_s;
   logic [3:0]    decile_r;
   logic [3:0]    dec_base_s;
   logic [3:0]    dec_next_s;
   logic [3:0]    speed_next_s;
   logic          vld_next_s;
   logic          err_next_s;
   logic          stuck_next_s;

   pin_sync #(.WIDTH(5)) u_pin_sync (
      .clk (clk),
      .d   ({pwm_in, IN1, IN2, IN3, IN4}),
      .q   (sync_s)
   );

   assign pwm_sync_s = sync_s[4];
   assign code_s     = decode_motion(sync_s[3:0]);

   // Edge register; the level is delayed alongside so counting sees the same timing as the edges.
   always_ff @(posedge clk) begin
      pwm_lvl_r <= pwm_sync_s;
      rise_r    <= pwm_sync_s & ~pwm_lvl_r;
      fall_r    <= ~pwm_sync_s & pwm_lvl_r;
   end

   // Stability count of the current candidate, restarting on any change and saturating at STABLE.
   always_comb begin
      stab_next_s = stab_cnt_r;
      if (code_s != cand_r) begin
         stab_next_s = CW'(1'b1);
      end else if (stab_cnt_r < STAB_MAX) begin
         stab_next_s = stab_cnt_r + CW'(1'b1);
      end else begin
         stab_next_s = stab_cnt_r;
      end
   end

   // Motion acceptance register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_r     <= MOT_STOP;
         stab_cnt_r <= {CW{1'b0}};
         motion     <= MOT_STOP;
         motion_chg <= 1'b0;
      end else begin
         cand_r     <= code_s;
         stab_cnt_r <= stab_next_s;
         if ((stab_next_s == STAB_MAX) && (code_s != motion)) begin
            motion     <= code_s;
            motion_chg <= 1'b1;
         end else begin
            motion_chg <= 1'b0;
         end
      end
   end

   // Speed FSM next state; per_inc_s is the period length including the current cycle.
   always_comb begin
      state_next_s = state_r;
      per_inc_s    = (per_cnt_r < PER_MAX) ? per_cnt_r + PW'(1'b1) : per_cnt_r;
      per_next_s   = per_inc_s;
      per_dev_s    = (per_inc_s > PER_NOM) ? per_inc_s - PER_NOM : PER_NOM - per_inc_s;
      step_base_s  = step_cnt_r;
      dec_base_s   = decile_r;
      speed_next_s = speed;
      vld_next_s   = 1'b0;
      err_next_s   = period_err;
      stuck_next_s = pwm_stuck;
      if (rise_r) begin
         state_next_s = ST_HIGH;
         per_next_s   = {PW{1'b0}};
         step_base_s  = {SW{1'b0}};
         dec_base_s   = 4'd0;
         stuck_next_s = 1'b0;
         if (state_r == ST_LOW) begin
            speed_next_s = decile_r;
            vld_next_s   = 1'b1;
            err_next_s   = (per_dev_s > PER_TOL);
         end else begin
            speed_next_s = speed;
         end
      end else if (per_inc_s == PER_MAX) begin
         state_next_s = ST_IDLE;
         per_next_s   = {PW{1'b0}};
         speed_next_s = pwm_lvl_r ? SPEED_MAX : 4'd0;
         vld_next_s   = 1'b1;
         stuck_next_s = 1'b1;
         err_next_s   = 1'b0;
      end else begin
         case (state_r)
            ST_HIGH: state_next_s = fall_r ? ST_LOW : ST_HIGH;
            ST_LOW:  state_next_s = ST_LOW;
            ST_IDLE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
         endcase
      end
      // The detecting cycle itself is the first high clock of the new period.
      if ((state_next_s == ST_HIGH) && pwm_lvl_r) begin
         if (step_base_s == STEP_LAST) begin
            step_next_s = {SW{1'b0}};
            dec_next_s  = (dec_base_s < SPEED_MAX) ? dec_base_s + 4'd1 : SPEED_MAX;
         end else begin
            step_next_s = step_base_s + SW'(1'b1);
            dec_next_s  = dec_base_s;
         end
      end else begin
         step_next_s = step_base_s;
         dec_next_s  = dec_base_s;
      end
   end

   // Speed FSM state, counters and published outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         per_cnt_r  <= {PW{1'b0}};
         step_cnt_r <= {SW{1'b0}};
         decile_r   <= 4'd0;
         speed      <= 4'd0;
         speed_vld  <= 1'b0;
         period_err <= 1'b0;
         pwm_stuck  <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         per_cnt_r  <= per_next_s;
         step_cnt_r <= step_next_s;
         decile_r   <= dec_next_s;
         speed      <= speed_next_s;
         speed_vld  <= vld_next_s;
         period_err <= err_next_s;
         pwm_stuck  <= stuck_next_s;
      end
   end

endmodule

// File: tb/tb_drive_monitor.sv
// Self-checking bench for drive_monitor: pin-history reference model compared
// every cycle, plus directed checks of the documented scenarios.
module tb_drive_monitor;

   localparam int PERIOD  = 100;
   localparam int TOL     = 2;
   localparam int TIMEOUT = 202;
   localparam int STABLE  = 4;
   localparam int STEP    = PERIOD / 10;
   localparam int HMAX    = 16384;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       pwm_in = 1'b0;
   logic       IN1    = 1'b0;
   logic       IN2    = 1'b0;
   logic       IN3    = 1'b0;
   logic       IN4    = 1'b0;
   logic [2:0] motion;
   logic       motion_chg;
   logic [3:0] speed;
   logic       speed_vld;
   logic       period_err;
   logic       pwm_stuck;

   drive_monitor #(
      .PERIOD  (PERIOD),
      .TOL     (TOL),
      .TIMEOUT (TIMEOUT),
      .STABLE  (STABLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .IN1        (IN1),
      .IN2        (IN2),
      .IN3        (IN3),
      .IN4        (IN4),
      .motion     (motion),
      .motion_chg (motion_chg),
      .speed      (speed),
      .speed_vld  (speed_vld),
      .period_err (period_err),
      .pwm_stuck  (pwm_stuck)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int e       = 8;
   int vld_seen = 0;

   logic       pin_hist [HMAX];
   logic [3:0] in_hist  [HMAX];
   logic       pin      = 1'b0;
   logic [3:0] in_pins  = 4'b0000;
   bit         rand_in  = 1'b0;

   // Reference model state, in terms of edge timestamps.
   bit         armed      = 1'b0;
   int         last_rise  = 0;
   int         last_clear = 0;
   int         last_rst   = 0;
   logic [3:0] m_speed    = 4'd0;
   logic       m_vld      = 1'b0;
   logic       m_err      = 1'b0;
   logic       m_stuck    = 1'b0;
   logic [2:0] m_motion   = 3'd0;
   logic       m_chg      = 1'b0;

   function automatic logic [2:0] ref_code(input logic [3:0] p);
      case (p)
         4'b0000: return 3'd0;
         4'b1010: return 3'd1;
         4'b0101: return 3'd2;
         4'b0110: return 3'd3;
         4'b1001: return 3'd4;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [3:0] pick_in();
      case ($urandom_range(5, 0))
         0: return 4'b0000;
         1: return 4'b1010;
         2: return 4'b0101;
         3: return 4'b0110;
         4: return 4'b1001;
         default: return 4'($urandom);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s edge=%0d got=%0d expected=%0d", tag, e, obs, exp);
      end
   endtask

   // Model for edge e: the FSM sees pin value applied 3 edges earlier; motion samples lag 2 edges.
   task automatic model_step(input logic r);
      logic       lvl;
      logic       rise;
      int         hi;
      int         dev;
      logic [2:0] c;
      bit         same;
      m_vld = 1'b0;
      m_chg = 1'b0;
      if (r) begin
         m_speed = 4'd0; m_err = 1'b0; m_stuck = 1'b0; m_motion = 3'd0;
         armed = 1'b0; last_clear = e; last_rst = e;
      end else begin
         lvl  = pin_hist[e-3];
         rise = lvl & ~pin_hist[e-4];
         if (rise) begin
            if (armed) begin
               hi = 0;
               for (int x = last_rise; x < e; x++) hi += int'(pin_hist[x-3]);
               m_speed = (hi / STEP >= 10) ? 4'd10 : 4'(hi / STEP);
               dev = (e - last_rise) - (PERIOD + 1);
               if (dev < 0) dev = -dev;
               m_err = (dev > TOL);
               m_vld = 1'b1;
            end
            armed = 1'b1; m_stuck = 1'b0; last_rise = e; last_clear = e;
         end else if (e - last_clear >= TIMEOUT) begin
            m_speed = lvl ? 4'd10 : 4'd0;
            m_vld = 1'b1; m_stuck = 1'b1; m_err = 1'b0;
            armed = 1'b0; last_clear = e;
         end
         if (e - STABLE >= last_rst) begin
            c = ref_code(in_hist[e-2]);
            same = 1'b1;
            for (int k = 1; k < STABLE; k++)
               if (ref_code(in_hist[e-2-k]) != c) same = 1'b0;
            if (same && (c != m_motion)) begin
               m_motion = c;
               m_chg = 1'b1;
            end
         end
      end
   endtask

   task automatic tick(input logic r);
      if (rand_in && ($urandom_range(15, 0) == 0)) in_pins = pick_in();
      rst = r;
      pwm_in = pin;
      {IN1, IN2, IN3, IN4} = in_pins;
      @(posedge clk);
      e++;
      if (e >= HMAX) begin
         $display("FAIL history_overflow edge=%0d", e);
         $fatal(1, "history overflow");
      end
      pin_hist[e] = pin;
      in_hist[e] = in_pins;
      model_step(r);
      @(negedge clk);
      if (speed_vld === 1'b1) vld_seen++;
      check("speed", 32'(speed), 32'(m_speed));
      check("speed_vld", 32'(speed_vld), 32'(m_vld));
      check("period_err", 32'(period_err), 32'(m_err));
      check("pwm_stuck", 32'(pwm_stuck), 32'(m_stuck));
      check("motion", 32'(motion), 32'(m_motion));
      check("motion_chg", 32'(motion_chg), 32'(m_chg));
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   task automatic pwm_run(input int h, input int l, input int reps);
      for (int r = 0; r < reps; r++) begin
         pin = 1'b1;
         for (int i = 0; i < h; i++) tick(1'b0);
         pin = 1'b0;
         for (int i = 0; i < l; i++) tick(1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < HMAX; i++) begin
         pin_hist[i] = 1'b0;
         in_hist[i] = 4'b0000;
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) tick(1'b1);
      check("rst_speed", 32'(speed), 32'd0);
      check("rst_motion", 32'(motion), 32'd0);
      check("rst_stuck", 32'(pwm_stuck), 32'd0);

      // Motion: accept after STABLE+2 clocks, ignore a short glitch, then ILLEGAL.
      hold(3);
      in_pins = 4'b1010;
      hold(5);
      check("chg_early", 32'(motion_chg), 32'd0);
      hold(1);
      check("chg_at6", 32'(motion_chg), 32'd1);
      check("motion_fwd", 32'(motion), 32'd1);
      hold(1);
      check("chg_single", 32'(motion_chg), 32'd0);
      hold(4);
      in_pins = 4'b0110;
      hold(2);
      in_pins = 4'b1010;
      hold(8);
      check("glitch_ignored", 32'(motion), 32'd1);
      in_pins = 4'b1100;
      hold(8);
      check("motion_illegal", 32'(motion), 32'd7);
      in_pins = 4'b1010;

      // Half duty at nominal period.
      pwm_run(50, 51, 4);
      check("speed_half", 32'(speed), 32'd5);
      check("err_half", 32'(period_err), 32'd0);

      // Full duty, then enable held low.
      pwm_run(100, 1, 3);
      check("speed_full", 32'(speed), 32'd10);
      vld_seen = 0;
      hold(450);
      check("stuck_speed", 32'(speed), 32'd0);
      check("stuck_flag", 32'(pwm_stuck), 32'd1);
      check("stuck_pulses", 32'(vld_seen), 32'd2);

      // Long period: first rising edge clears stuck, later publishes flag the period.
      pwm_run(30, 90, 4);
      check("speed_30", 32'(speed), 32'd3);
      check("err_long", 32'(period_err), 32'd1);
      check("stuck_cleared", 32'(pwm_stuck), 32'd0);

      // Reset halfway through a HIGH phase at speed 7.
      pwm_run(70, 31, 3);
      check("speed_70", 32'(speed), 32'd7);
      pin = 1'b1;
      hold(35);
      tick(1'b1);
      check("midrst_speed", 32'(speed), 32'd0);
      check("midrst_motion", 32'(motion), 32'd0);
      check("midrst_err", 32'(period_err), 32'd0);
      hold(34);
      pin = 1'b0;
      hold(31);
      pwm_run(70, 31, 1);
      check("no_pub_first_edge", 32'(speed), 32'd0);
      pwm_run(70, 31, 1);
      check("pub_after_rst", 32'(speed), 32'd7);

      // Randomized periods, duty and direction pins, with occasional timeouts.
      rand_in = 1'b1;
      for (int p = 0; p < 25; p++) begin
         int h;
         int l;
         h = $urandom_range(110, 0);
         l = ($urandom_range(5, 0) == 0) ? $urandom_range(260, 150) : $urandom_range(60, 1);
         pwm_run(h, l, 1);
      end
      rand_in = 1'b0;
      hold(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
